// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
// Contents:
//   CTR_*      : 2-bit saturating direction counter encodings
//   idx_width  : table index width derived from the entry count
package branch_predictor_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    function automatic int unsigned idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Ports:
//   clk, rst        : clock (rising edge), async active-high reset
//   pc_if           : IF-stage PC looked up combinationally
//   pred_hit/taken  : lookup result for pc_if
//   pred_target     : entry target when predicted taken, else pc_if+4
//   upd_*           : resolved branch/jump from EX, applied at the clock edge
//   invalidate      : clears every entry's valid bit (wins over an update)
//   cnt_branches    : saturating count of upd_valid cycles
//   cnt_mispred     : saturating count of upd_valid && upd_mispredict cycles
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 64,
    parameter logic [1:0]  CTR_INIT = CTR_WNT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_if,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_mispredict,
    input  logic             invalidate,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int unsigned     IDX_W   = idx_width(ENTRIES);
    localparam int unsigned     TAG_W   = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              valid_q   [ENTRIES];
    logic              valid_d   [ENTRIES];
    logic [TAG_W-1:0]  tag_q     [ENTRIES];
    logic [TAG_W-1:0]  tag_d     [ENTRIES];
    logic [XLEN-1:0]   target_q  [ENTRIES];
    logic [XLEN-1:0]   target_d  [ENTRIES];
    logic [1:0]        ctr_q     [ENTRIES];
    logic [1:0]        ctr_d     [ENTRIES];
    logic              is_jump_q [ENTRIES];
    logic              is_jump_d [ENTRIES];

    logic [CNT_W-1:0]  cnt_br_q, cnt_br_d;
    logic [CNT_W-1:0]  cnt_mp_q, cnt_mp_d;

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              up_hit;

    // Byte-offset bits of a word-aligned PC carry no information here.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

    function automatic logic [1:0] sat_ctr2_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
    endfunction

    assign lk_idx = pc_if[IDX_W+1:2];
    assign lk_tag = pc_if[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][1]);
        pred_target = pred_taken ? target_q[lk_idx] : pc_if + PC_STEP;
    end

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        is_jump_d = is_jump_q;
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

        if (invalidate) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_is_jump) begin
                    ctr_d[up_idx]     = CTR_ST;
                    is_jump_d[up_idx] = 1'b1;
                    target_d[up_idx]  = upd_target;
                end else begin
                    ctr_d[up_idx] = sat_ctr2_next(ctr_q[up_idx], upd_taken);
                    if (upd_taken) begin
                        target_d[up_idx] = upd_target;
                    end
                end
            end else if (upd_taken) begin
                valid_d[up_idx]   = 1'b1;
                tag_d[up_idx]     = up_tag;
                target_d[up_idx]  = upd_target;
                is_jump_d[up_idx] = upd_is_jump;
                ctr_d[up_idx]     = upd_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    // Perf counters keep counting through invalidate and stick at all-ones.
    always_comb begin
        cnt_br_d = cnt_br_q;
        cnt_mp_d = cnt_mp_q;
        if (upd_valid && (cnt_br_q != '1)) begin
            cnt_br_d = cnt_br_q + CNT_ONE;
        end
        if (upd_valid && upd_mispredict && (cnt_mp_q != '1)) begin
            cnt_mp_d = cnt_mp_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                ctr_q[i]     <= CTR_INIT;
                is_jump_q[i] <= 1'b0;
            end
            cnt_br_q <= '0;
            cnt_mp_q <= '0;
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            ctr_q     <= ctr_d;
            is_jump_q <= is_jump_d;
            cnt_br_q  <= cnt_br_d;
            cnt_mp_q  <= cnt_mp_d;
        end
    end

    assign cnt_branches = cnt_br_q;
    assign cnt_mispred  = cnt_mp_q;

endmodule
